// File: rtl/riscv_pkg.sv
// Shared encodings and widths for the RV32I pipeline execute logic.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // 2'b11 is reserved and behaves like FWD_RF
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiplier (W x W -> low W bits), one partial product per cycle.
// Instantiated by ex_stage only when EX_MUL_EN is defined.
module mul_shift_add
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  mul_state_e     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  // Stall must drop as soon as reset is applied, even with start still held high.
  assign busy_o   = ~rst & (((state_q == MUL_IDLE) & start_i) | (state_q == MUL_BUSY));
  assign done_o   = (state_q == MUL_DONE);
  assign result_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage with inline ALU, branch resolution and EX/MEM register.
// Define EX_MUL_EN to include the sequential multiplier (stalls the front end while busy).
module ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic            MulE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  import riscv_pkg::*;

  logic            reg_write_q, mem_write_q;
  logic [1:0]      result_src_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, ex_result;
  logic            zero;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SRL: alu_result = src_a >> src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

`ifdef EX_MUL_EN
  logic            mul_busy, mul_done;
  logic [XLEN-1:0] mul_result;

  mul_shift_add #(.W(XLEN)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (MulE),
    .a_i      (src_a),
    .b_i      (fwd_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .result_o (mul_result)
  );

  assign StallE    = mul_busy;
  assign ex_result = mul_done ? mul_result : alu_result;
`else
  logic unused_mul;
  assign unused_mul = MulE;
  assign StallE     = 1'b0;
  assign ex_result  = alu_result;
`endif

  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = ~StallE & ((BranchE & zero) | JumpE);

  // A stalled EX slot is sent down as a bubble rather than held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || StallE) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      result_src_q <= ResultSrcE;
      rd_q         <= RdE;
      alu_result_q <= ex_result;
      write_data_q <= fwd_b;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RdM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule
